alu_input_loader: RTL

Front-end operand loader that feeds the ALU: samples the board switches into the A, B and OP registers on debounced button presses and drives them straight into the ALU's `i_A`, `i_B` and `i_OP` inputs. A small FSM enforces the load order A → B → OP and flags when a complete operand set is present. Sits between the board I/O pins and the ALU; the ALU's `o_led` result path is untouched.

---
 rtl/alu_input_loader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu_input_loader.sv
// Operand loader for the ALU: synchronizes switches/buttons, filters button bounce
// and loads A -> B -> OP in order. Debounce filter present only with ALU_LOADER_DEBOUNCE_EN.
module alu_input_loader #(
   parameter int NB_DATA         = 8,
   parameter int NB_OP           = 6,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NB_DATA-1:0] i_sw,
   input  logic [2:0]         i_btn,
   output logic [NB_DATA-1:0] o_A,
   output logic [NB_DATA-1:0] o_B,
   output logic [NB_OP-1:0]   o_OP,
   output logic               o_valid,
   output logic [1:0]         o_state
);

   // state   | meaning
   // WAIT_A  | nothing loaded, only A accepted
   // WAIT_B  | A loaded, waiting for B (A may be reloaded)
   // WAIT_OP | A and B loaded, waiting for OP
   // DONE    | full operand set present, o_valid high
   localparam logic [1:0] WAIT_A  = 2'd0;
   localparam logic [1:0] WAIT_B  = 2'd1;
   localparam logic [1:0] WAIT_OP = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   if (DEBOUNCE_CYCLES < 2) begin : g_param_check
      $error("DEBOUNCE_CYCLES must be at least 2");
   end

   logic [2:0]         btn_s1, btn_s2;
   logic [NB_DATA-1:0] sw_s1, sw_s2;
   logic [1:0]         settle;
   logic [2:0]         armed;
   logic [2:0]         lvl, lvl_d;
   logic [2:0]         pulse;

   // A button is armed only after a genuine post-reset low sample, so a button
   // held through reset release cannot fire until it is released and re-pressed.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         btn_s1 <= '0;
         btn_s2 <= '0;
         sw_s1  <= '0;
         sw_s2  <= '0;
         settle <= '0;
         armed  <= '0;
         lvl_d  <= '0;
      end else begin
         btn_s1 <= i_btn;
         btn_s2 <= btn_s1;
         sw_s1  <= i_sw;
         sw_s2  <= sw_s1;
         settle <= {settle[0], 1'b1};
         for (int i = 0; i < 3; i++) begin
            if (settle[1] && !btn_s2[i])
               armed[i] <= 1'b1;
         end
         lvl_d  <= lvl;
      end
   end

`ifdef ALU_LOADER_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [2:0]    deb;
   logic [CW-1:0] cnt [3];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         deb <= '0;
         for (int i = 0; i < 3; i++)
            cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (btn_s2[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               deb[i] <= btn_s2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   assign lvl = deb;
`else
   assign lvl = btn_s2;
`endif

   assign pulse = lvl & ~lvl_d & armed;

   logic [1:0] state, state_nx;
   logic       ld_a, ld_b, ld_op;

   always_comb begin
      state_nx = state;
      ld_a     = 1'b0;
      ld_b     = 1'b0;
      ld_op    = 1'b0;
      if (pulse[0]) begin
         ld_a     = 1'b1;
         state_nx = WAIT_B;
      end else if (pulse[1] && state != WAIT_A) begin
         ld_b = 1'b1;
         if (state == WAIT_B)
            state_nx = WAIT_OP;
      end else if (pulse[2] && (state == WAIT_OP || state == DONE)) begin
         ld_op    = 1'b1;
         state_nx = DONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state   <= WAIT_A;
         o_valid <= 1'b0;
         o_A     <= '0;
         o_B     <= '0;
         o_OP    <= '0;
      end else begin
         state   <= state_nx;
         o_valid <= (state_nx == DONE);
         if (ld_a)  o_A  <= sw_s2;
         if (ld_b)  o_B  <= sw_s2;
         if (ld_op) o_OP <= sw_s2[NB_OP-1:0];
      end
   end

   assign o_state = state;

endmodule
